// File: rtl/dmux8_mask_sequencer_if.sv
// Handshake/bus bundle between a mask source and the demux sequencer.
// The sequencer drives in/sel/busy/done/count; the source drives start/mask/hold.
`timescale 1ns/1ps
interface dmux8_mask_sequencer_if;
    logic       start;
    logic [7:0] mask;
    logic       hold;
    logic       in;
    logic [0:2] sel;
    logic       busy;
    logic       done;
    logic [3:0] count;

    modport master (output start, mask, hold, input in, sel, busy, done, count);
    modport slave  (input start, mask, hold, output in, sel, busy, done, count);
endinterface

// File: rtl/dmux8_mask_sequencer.sv
// Walks an 8-bit destination mask and issues one registered demux strobe per set bit.
// HIGH_FIRST selects whether the highest or the lowest pending index goes first.
`timescale 1ns/1ps
module dmux8_mask_sequencer #(
    parameter bit HIGH_FIRST = 1'b0
) (
    input logic                   clk,
    input logic                   reset,
    dmux8_mask_sequencer_if.slave bus
);
    localparam int unsigned N_DEST = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_DEST-1:0] pending_q, pending_d;
    logic              in_q, in_d;
    logic [0:IDX_W-1]  sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [N_DEST-1:0] scan_src;
    logic [IDX_W-1:0]  idx;
    logic [N_DEST-1:0] idx_bit;

    // First set bit of v in the configured scan order.
    function automatic logic [IDX_W-1:0] first_set(input logic [N_DEST-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_DEST); i++) begin
            if (HIGH_FIRST) begin
                if (v[IDX_W'(i)]) r = IDX_W'(i);
            end else begin
                if (v[IDX_W'(int'(N_DEST) - 1 - i)]) r = IDX_W'(int'(N_DEST) - 1 - i);
            end
        end
        return r;
    endfunction

    // The first strobe is issued on the accepting edge, so IDLE scans the live mask.
    always_comb begin
        scan_src = (state_q == IDLE) ? bus.mask : pending_q;
        idx      = first_set(scan_src);
        idx_bit  = N_DEST'(1) << idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            in_q      <= 1'b0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            in_q      <= in_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    // RUN with pending empty means the last strobe is on the pins; finish next.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        in_d      = 1'b0;
        sel_d     = sel_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d = '0;
                    if (bus.mask != '0) begin
                        pending_d = bus.mask & ~idx_bit;
                        in_d      = 1'b1;
                        sel_d     = {idx[0], idx[1], idx[2]};
                        busy_d    = 1'b1;
                        count_d   = CNT_W'(1);
                        state_d   = RUN;
                    end else begin
                        pending_d = '0;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            RUN: begin
                if (pending_q == '0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (bus.hold) begin
                    busy_d = 1'b1;
                end else begin
                    pending_d = pending_q & ~idx_bit;
                    in_d      = 1'b1;
                    sel_d     = {idx[0], idx[1], idx[2]};
                    busy_d    = 1'b1;
                    count_d   = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in    = in_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_dmux8_mask_sequencer.sv
// Bench for dmux8_mask_sequencer: both scan orders side by side, directed cases
// with literal expectations, then random traffic against a destination-list model.
`timescale 1ns/1ps
module tb_dmux8_mask_sequencer;
    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] mask;
    logic       hold;

    int n_checks = 0;
    int n_errors = 0;

    dmux8_mask_sequencer_if bus_lo ();
    dmux8_mask_sequencer_if bus_hi ();

    assign bus_lo.start = start;
    assign bus_lo.mask  = mask;
    assign bus_lo.hold  = hold;
    assign bus_hi.start = start;
    assign bus_hi.mask  = mask;
    assign bus_hi.hold  = hold;

    dmux8_mask_sequencer #(.HIGH_FIRST(1'b0)) dut_lo (.clk(clk), .reset(reset), .bus(bus_lo));
    dmux8_mask_sequencer #(.HIGH_FIRST(1'b1)) dut_hi (.clk(clk), .reset(reset), .bus(bus_hi));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] sel_idx(input logic [0:2] s);
        return 32'({s[2], s[1], s[0]});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the accepted mask becomes an ordered list of destinations that is popped once per
    // unheld cycle; an exhausted list yields a done cycle, then idle.
    int ord   [2][8];
    int n_dst [2];
    int ptr   [2];
    int ph    [2];  // 0 idle, 1 issuing, 2 done
    int m_in  [2];
    int m_sel [2];
    int m_busy[2];
    int m_done[2];
    int m_cnt [2];

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    n_dst[k] = 0; ptr[k] = 0; ph[k] = 0;
                    m_in[k] = 0; m_sel[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_cnt[k] = 0;
                end else begin
                    m_in[k]   = 0;
                    m_done[k] = 0;
                    m_busy[k] = 0;
                    if (ph[k] == 0) begin
                        if (start) begin
                            m_cnt[k] = 0;
                            n_dst[k] = 0;
                            ptr[k]   = 0;
                            for (int j = 0; j < 8; j++) begin
                                int d;
                                d = (k == 1) ? 7 - j : j;
                                if (mask[d]) begin
                                    ord[k][n_dst[k]] = d;
                                    n_dst[k]++;
                                end
                            end
                            if (n_dst[k] == 0) begin
                                ph[k] = 2; m_done[k] = 1;
                            end else begin
                                m_sel[k] = ord[k][0]; ptr[k] = 1;
                                m_in[k] = 1; m_busy[k] = 1; m_cnt[k] = 1; ph[k] = 1;
                            end
                        end
                    end else if (ph[k] == 1) begin
                        if (ptr[k] == n_dst[k]) begin
                            ph[k] = 2; m_done[k] = 1;
                        end else if (hold) begin
                            m_busy[k] = 1;
                        end else begin
                            m_sel[k] = ord[k][ptr[k]]; ptr[k]++;
                            m_in[k] = 1; m_busy[k] = 1; m_cnt[k]++;
                        end
                    end else begin
                        ph[k] = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("lo_in",    32'(bus_lo.in),    32'(m_in[0]));
            chk("lo_sel",   sel_idx(bus_lo.sel), 32'(m_sel[0]));
            chk("lo_busy",  32'(bus_lo.busy),  32'(m_busy[0]));
            chk("lo_done",  32'(bus_lo.done),  32'(m_done[0]));
            chk("lo_count", 32'(bus_lo.count), 32'(m_cnt[0]));
            chk("hi_in",    32'(bus_hi.in),    32'(m_in[1]));
            chk("hi_sel",   sel_idx(bus_hi.sel), 32'(m_sel[1]));
            chk("hi_busy",  32'(bus_hi.busy),  32'(m_busy[1]));
            chk("hi_done",  32'(bus_hi.done),  32'(m_done[1]));
            chk("hi_count", 32'(bus_hi.count), 32'(m_cnt[1]));
        end
    end

    task automatic tick(input bit st, input logic [7:0] m, input bit h);
        start = st;
        mask  = m;
        hold  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lo_in"},    32'(bus_lo.in),      32'd0);
        chk({tag, "_lo_sel"},   sel_idx(bus_lo.sel), 32'd0);
        chk({tag, "_lo_busy"},  32'(bus_lo.busy),    32'd0);
        chk({tag, "_lo_done"},  32'(bus_lo.done),    32'd0);
        chk({tag, "_lo_count"}, 32'(bus_lo.count),   32'd0);
        chk({tag, "_hi_in"},    32'(bus_hi.in),      32'd0);
        chk({tag, "_hi_sel"},   sel_idx(bus_hi.sel), 32'd0);
        chk({tag, "_hi_busy"},  32'(bus_hi.busy),    32'd0);
        chk({tag, "_hi_done"},  32'(bus_hi.done),    32'd0);
        chk({tag, "_hi_count"}, 32'(bus_hi.count),   32'd0);
    endtask

    int a5_lo[4]  = '{0, 2, 5, 7};
    int a5_hi[4]  = '{7, 5, 2, 0};
    int ff_lo[10] = '{0, 1, 1, 1, 2, 3, 4, 5, 6, 7};
    int ff_hi[10] = '{7, 6, 6, 6, 5, 4, 3, 2, 1, 0};
    int ff_cn[12] = '{1, 2, 2, 2, 3, 4, 5, 6, 7, 8, 8, 8};

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mask  = 8'h00;
        hold  = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick(0, 8'h00, 0);

        // A5: strobes in cycles 1-4; start and mask changes during RUN are ignored.
        tick(1, 8'hA5, 0);
        for (int c = 1; c <= 6; c++) begin
            chk("a5_lo_in",   32'(bus_lo.in),   32'(c <= 4));
            chk("a5_hi_in",   32'(bus_hi.in),   32'(c <= 4));
            chk("a5_lo_busy", 32'(bus_lo.busy), 32'(c <= 4));
            chk("a5_hi_busy", 32'(bus_hi.busy), 32'(c <= 4));
            chk("a5_lo_done", 32'(bus_lo.done), 32'(c == 5));
            chk("a5_hi_done", 32'(bus_hi.done), 32'(c == 5));
            if (c <= 4) begin
                chk("a5_lo_sel", sel_idx(bus_lo.sel), 32'(a5_lo[c-1]));
                chk("a5_hi_sel", sel_idx(bus_hi.sel), 32'(a5_hi[c-1]));
            end
            if (c >= 5) begin
                chk("a5_lo_count", 32'(bus_lo.count), 32'd4);
                chk("a5_hi_count", 32'(bus_hi.count), 32'd4);
            end
            tick(c == 1, 8'h3C, 0);
        end

        // FF with hold sampled on the edges that open cycles 3 and 4.
        tick(1, 8'hFF, 0);
        for (int c = 1; c <= 12; c++) begin
            chk("ff_lo_in",    32'(bus_lo.in),    32'(c <= 10 && c != 3 && c != 4));
            chk("ff_hi_in",    32'(bus_hi.in),    32'(c <= 10 && c != 3 && c != 4));
            chk("ff_lo_busy",  32'(bus_lo.busy),  32'(c <= 10));
            chk("ff_lo_done",  32'(bus_lo.done),  32'(c == 11));
            chk("ff_hi_done",  32'(bus_hi.done),  32'(c == 11));
            chk("ff_lo_count", 32'(bus_lo.count), 32'(ff_cn[c-1]));
            if (c <= 10) begin
                chk("ff_lo_sel", sel_idx(bus_lo.sel), 32'(ff_lo[c-1]));
                chk("ff_hi_sel", sel_idx(bus_hi.sel), 32'(ff_hi[c-1]));
            end
            tick(0, 8'h00, (c == 2 || c == 3));
        end

        // Empty mask, then a start during DONE is dropped and a start in IDLE is taken.
        tick(1, 8'h00, 0);
        chk("m0_done",  32'(bus_lo.done),  32'd1);
        chk("m0_busy",  32'(bus_lo.busy),  32'd0);
        chk("m0_in",    32'(bus_lo.in),    32'd0);
        chk("m0_count", 32'(bus_lo.count), 32'd0);
        tick(1, 8'h80, 0);
        chk("m0_ign_in",    32'(bus_lo.in),    32'd0);
        chk("m0_ign_busy",  32'(bus_hi.busy),  32'd0);
        chk("m0_ign_done",  32'(bus_lo.done),  32'd0);
        chk("m0_ign_count", 32'(bus_hi.count), 32'd0);
        tick(1, 8'h80, 0);
        chk("m80_lo_in",  32'(bus_lo.in),        32'd1);
        chk("m80_lo_sel", sel_idx(bus_lo.sel),   32'd7);
        chk("m80_hi_sel", sel_idx(bus_hi.sel),   32'd7);
        chk("m80_count",  32'(bus_lo.count),     32'd1);
        tick(0, 8'h00, 0);
        chk("m80_done",     32'(bus_lo.done),    32'd1);
        chk("m80_sel_hold", sel_idx(bus_lo.sel), 32'd7);
        tick(0, 8'h00, 0);

        // Reset mid-cycle 3 of an FF sequence: outputs clear before any edge, no done.
        tick(1, 8'hFF, 0);
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 0);
        #2;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(0, 8'h00, 0);
            chk("rst_no_done", 32'(bus_lo.done), 32'd0);
            chk("rst_no_busy", 32'(bus_hi.busy), 32'd0);
        end
        tick(1, 8'h01, 0);
        chk("m01_in",    32'(bus_lo.in),      32'd1);
        chk("m01_sel",   sel_idx(bus_hi.sel), 32'd0);
        chk("m01_count", 32'(bus_lo.count),   32'd1);
        tick(0, 8'h00, 0);
        chk("m01_done",  32'(bus_lo.done),    32'd1);
        chk("m01_in_lo", 32'(bus_lo.in),      32'd0);
        tick(0, 8'h00, 0);

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] m;
            int         r;
            m = 8'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 0) m = 8'h00;
            if (r == 1) m = 8'hFF;
            tick(($urandom_range(0, 3) == 0), m, ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset = 1'b1;
                @(posedge clk);
                #3;
                reset = 1'b0;
            end
        end
        tick(0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmux8_mask_sequencer.md
# dmux8_mask_sequencer

Sequencer that drives the `in`/`sel` pins of an 8-way demultiplexer, such as the one feeding the load lines of a RAM8 bank. It accepts an 8-bit destination mask and emits one single-cycle load strobe per set bit, one destination per cycle. It lets a single upstream source broadcast or scatter-load into any subset of the eight outputs. Stalls are handled with a hold input.

## Interface
Parameters:
- `HIGH_FIRST`, default 0: scan order. 0 issues the lowest set index first; 1 issues the highest set index first.

Ports:
- `clk`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to begin a sequence. Sampled only in IDLE.
- `mask`  in  8  destination set. Bit i selects demux output i (a=0 … h=7). Latched when `start` is accepted.
- `hold`  in  1  stall. While high in RUN, no strobe is issued and state is frozen.
- `in`  out  1  strobe to the demux `in` pin. High for exactly one cycle per destination.
- `sel`  out  [0:2]  demux select. `sel[0]` has weight 1 and `sel[2]` has weight 4; index i maps to sel = i.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `count`  out  4  number of strobes issued in the current or last sequence (0–8).

## Operation
- All outputs are registered.
- Reset values: `in`=0, `sel`=000, `busy`=0, `done`=0, `count`=0, pending=0, state=IDLE.
- States:
  - **IDLE**: when `start`=1, latch `mask` into pending and clear `count`. If `mask`≠0, go to RUN; if `mask`=0, go to DONE (no strobes).
  - **RUN**, `hold`=0: select the index i of the first set pending bit in scan order. Register `sel`=i and `in`=1, clear pending bit i, and increment `count`. If pending becomes 0, go to DONE.
  - **RUN**, `hold`=1: `in`=0, `sel`/pending/`count` unchanged, stay in RUN.
  - **DONE**: `done`=1 and `in`=0 for one cycle, then go to IDLE.
- `start` in RUN or DONE is ignored; it is neither queued nor re-latched.
- Changes to `mask` after acceptance have no effect on the sequence in progress.
- `sel` holds its last issued value while `in`=0. It never changes without a strobe, except on reset.
- `count` holds its final value until the next accepted `start`.
- Asserting `reset` mid-sequence:
  - All outputs drop to their reset values immediately, without waiting for a clock edge.
  - Pending is discarded.
  - No `done` pulse is issued for the aborted sequence.

## Timing
- A `start` sampled at edge 0 with k set bits and no hold produces:
  - strobes (`in`=1, `busy`=1) in cycles 1…k;
  - `done` in cycle k+1, with `busy`=0 in that cycle;
  - IDLE from cycle k+2, where a new `start` is accepted.
- Latency from `start` to first strobe: 1 cycle.
- Throughput: 1 destination per cycle.
- Each cycle of `hold`=1 in RUN extends the sequence by exactly 1 cycle.
- `hold` has no effect in IDLE or DONE.
- `busy` is high in every RUN cycle, including held cycles.
- A `mask`=0 start gives `done` in cycle 1, with `busy` never asserted and `count`=0.
- A full mask (FF) gives 8 strobes, `count`=8, and `done` in cycle 9.

## Test plan
- Reset, then `start` with mask=8'b1010_0101 and HIGH_FIRST=0 → strobes in cycles 1–4 with sel=0,2,5,7; `done` in cycle 5; `count`=4.
- Same mask with HIGH_FIRST=1 → sel=7,5,2,0; each strobe exactly one cycle wide; `busy` high in cycles 1–4 only.
- mask=FF with `hold`=1 in cycles 3–4 → strobes in cycles 1,2,5,6,7,8,9,10 with sel=0…7 in order; `in`=0 and `sel`=1 held in cycles 3–4; `done` in cycle 11; `count`=8.
- mask=00 → no strobe, `busy` stays 0, `done` in cycle 1, `count`=0. Then a second `start` with mask=0x80, asserted in the DONE cycle, is ignored; reasserted in IDLE, it gives one strobe with sel=7.
- mask=FF, `reset` asserted mid-cycle 3 → all outputs 0 without waiting for an edge, and no `done` pulse. After release, `start` with mask=0x01 gives a single strobe with sel=0, then `done`.
